// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: routes one Wishbone master to one of three slave windows
// (BaseRAM, ExtRAM, UART). Decoding takes one cycle, a stalled slave is aborted
// after TIMEOUT_CYCLES, and an address that matches no window gets a one-cycle error.
module wb_slave_decoder #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE        = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK        = 32'hFFC0_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE        = 32'h8040_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK        = 32'hFFC0_0000,
  parameter logic [ADDR_WIDTH-1:0] S2_BASE        = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] S2_MASK        = 32'hFFFF_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // upstream master port
  input  logic [ADDR_WIDTH-1:0]   wb_m_adr,
  input  logic [DATA_WIDTH-1:0]   wb_m_dat_o,
  input  logic                    wb_m_we,
  input  logic [DATA_WIDTH/8-1:0] wb_m_sel,
  input  logic                    wb_m_stb,
  input  logic                    wb_m_cyc,
  output logic [DATA_WIDTH-1:0]   wb_m_dat_i,
  output logic                    wb_m_ack,
  output logic                    wb_m_err,
  output logic                    wb_m_rty,
  // downstream slave 0 (BaseRAM)
  output logic [ADDR_WIDTH-1:0]   wb_s0_adr,
  output logic [DATA_WIDTH-1:0]   wb_s0_dat_o,
  output logic                    wb_s0_we,
  output logic [DATA_WIDTH/8-1:0] wb_s0_sel,
  output logic                    wb_s0_stb,
  output logic                    wb_s0_cyc,
  input  logic [DATA_WIDTH-1:0]   wb_s0_dat_i,
  input  logic                    wb_s0_ack,
  input  logic                    wb_s0_err,
  input  logic                    wb_s0_rty,
  // downstream slave 1 (ExtRAM)
  output logic [ADDR_WIDTH-1:0]   wb_s1_adr,
  output logic [DATA_WIDTH-1:0]   wb_s1_dat_o,
  output logic                    wb_s1_we,
  output logic [DATA_WIDTH/8-1:0] wb_s1_sel,
  output logic                    wb_s1_stb,
  output logic                    wb_s1_cyc,
  input  logic [DATA_WIDTH-1:0]   wb_s1_dat_i,
  input  logic                    wb_s1_ack,
  input  logic                    wb_s1_err,
  input  logic                    wb_s1_rty,
  // downstream slave 2 (UART)
  output logic [ADDR_WIDTH-1:0]   wb_s2_adr,
  output logic [DATA_WIDTH-1:0]   wb_s2_dat_o,
  output logic                    wb_s2_we,
  output logic [DATA_WIDTH/8-1:0] wb_s2_sel,
  output logic                    wb_s2_stb,
  output logic                    wb_s2_cyc,
  input  logic [DATA_WIDTH-1:0]   wb_s2_dat_i,
  input  logic                    wb_s2_ack,
  input  logic                    wb_s2_err,
  input  logic                    wb_s2_rty,
  // status
  output logic                    busy_o,
  output logic                    timeout_o,
  output logic                    decerr_o
);

  localparam int          SEL_WIDTH     = DATA_WIDTH / 8;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DECERR  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  sel_r;
  logic [15:0] wait_cnt_r;
  logic        busy_r;
  logic        timeout_r;
  logic        decerr_r;

  logic [2:0]            hit_s;
  logic                  any_hit_s;
  logic [1:0]            dec_idx_s;
  logic                  active_s;
  logic                  sel_ack_s;
  logic                  sel_err_s;
  logic                  sel_rty_s;
  logic [DATA_WIDTH-1:0] sel_dat_s;
  logic                  term_s;

  // slave-side buses gathered into arrays so routing can be written once
  logic [ADDR_WIDTH-1:0] s_adr_s   [3];
  logic [DATA_WIDTH-1:0] s_dat_o_s [3];
  logic                  s_we_s    [3];
  logic [SEL_WIDTH-1:0]  s_sel_s   [3];
  logic                  s_stb_s   [3];
  logic                  s_cyc_s   [3];

  assign hit_s[0]  = ((wb_m_adr & S0_MASK) == S0_BASE);
  assign hit_s[1]  = ((wb_m_adr & S1_MASK) == S1_BASE);
  assign hit_s[2]  = ((wb_m_adr & S2_MASK) == S2_BASE);
  assign any_hit_s = |hit_s;
  assign active_s  = (state_r == ST_ACTIVE);

  // Priority encode the window hits: S0 wins over S1, S1 over S2; a miss selects 0
  always_comb begin
    dec_idx_s = 2'd0;
    casez (hit_s)
      3'b??1:  dec_idx_s = 2'd0;
      3'b?10:  dec_idx_s = 2'd1;
      3'b100:  dec_idx_s = 2'd2;
      default: dec_idx_s = 2'd0;
    endcase
  end

  // Pick the response of the registered slave only; other slaves are never observed
  always_comb begin
    sel_ack_s = 1'b0;
    sel_err_s = 1'b0;
    sel_rty_s = 1'b0;
    sel_dat_s = '0;
    case (sel_r)
      2'd0: begin
        sel_ack_s = wb_s0_ack;
        sel_err_s = wb_s0_err;
        sel_rty_s = wb_s0_rty;
        sel_dat_s = wb_s0_dat_i;
      end
      2'd1: begin
        sel_ack_s = wb_s1_ack;
        sel_err_s = wb_s1_err;
        sel_rty_s = wb_s1_rty;
        sel_dat_s = wb_s1_dat_i;
      end
      2'd2: begin
        sel_ack_s = wb_s2_ack;
        sel_err_s = wb_s2_err;
        sel_rty_s = wb_s2_rty;
        sel_dat_s = wb_s2_dat_i;
      end
      default: begin
        sel_ack_s = 1'b0;
        sel_err_s = 1'b0;
        sel_rty_s = 1'b0;
        sel_dat_s = '0;
      end
    endcase
  end

  // An access ends on any slave termination or when the master drops cyc
  assign term_s = sel_ack_s | sel_err_s | sel_rty_s | ~wb_m_cyc;

  // Combinational routing: master request to the selected slave, its response back
  always_comb begin
    wb_m_dat_i = '0;
    wb_m_ack   = 1'b0;
    wb_m_err   = 1'b0;
    wb_m_rty   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_adr_s[k]   = (active_s && (sel_r == 2'(k))) ? wb_m_adr   : '0;
      s_dat_o_s[k] = (active_s && (sel_r == 2'(k))) ? wb_m_dat_o : '0;
      s_we_s[k]    = (active_s && (sel_r == 2'(k))) ? wb_m_we    : 1'b0;
      s_sel_s[k]   = (active_s && (sel_r == 2'(k))) ? wb_m_sel   : '0;
      s_stb_s[k]   = (active_s && (sel_r == 2'(k))) ? wb_m_stb   : 1'b0;
      s_cyc_s[k]   = (active_s && (sel_r == 2'(k))) ? wb_m_cyc   : 1'b0;
    end
    case (state_r)
      ST_ACTIVE: begin
        wb_m_dat_i = sel_dat_s;
        wb_m_ack   = sel_ack_s;
        // ack wins so a misbehaving slave can never make ack and err coincide
        wb_m_err   = sel_err_s & ~sel_ack_s;
        wb_m_rty   = sel_rty_s & ~sel_ack_s & ~sel_err_s;
      end
      ST_DECERR: begin
        wb_m_err = 1'b1;
      end
      ST_TIMEOUT: begin
        wb_m_err = 1'b1;
      end
      ST_IDLE: begin
        wb_m_err = 1'b0;
      end
      default: begin
        wb_m_err = 1'b0;
      end
    endcase
  end

  // Decoder FSM with wait counter and registered status pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      sel_r      <= 2'd0;
      wait_cnt_r <= 16'd0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      decerr_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      decerr_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (wb_m_cyc && wb_m_stb) begin
            sel_r      <= dec_idx_s;
            wait_cnt_r <= 16'd0;
            busy_r     <= 1'b1;
            if (any_hit_s) begin
              state_r <= ST_ACTIVE;
            end else begin
              state_r  <= ST_DECERR;
              decerr_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          // termination is tested first so an ack on the limit cycle completes normally
          if (term_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (wait_cnt_r == TIMEOUT_LIMIT) begin
            state_r   <= ST_TIMEOUT;
            timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_DECERR: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        ST_TIMEOUT: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_s0_adr   = s_adr_s[0];
  assign wb_s0_dat_o = s_dat_o_s[0];
  assign wb_s0_we    = s_we_s[0];
  assign wb_s0_sel   = s_sel_s[0];
  assign wb_s0_stb   = s_stb_s[0];
  assign wb_s0_cyc   = s_cyc_s[0];

  assign wb_s1_adr   = s_adr_s[1];
  assign wb_s1_dat_o = s_dat_o_s[1];
  assign wb_s1_we    = s_we_s[1];
  assign wb_s1_sel   = s_sel_s[1];
  assign wb_s1_stb   = s_stb_s[1];
  assign wb_s1_cyc   = s_cyc_s[1];

  assign wb_s2_adr   = s_adr_s[2];
  assign wb_s2_dat_o = s_dat_o_s[2];
  assign wb_s2_we    = s_we_s[2];
  assign wb_s2_sel   = s_sel_s[2];
  assign wb_s2_stb   = s_stb_s[2];
  assign wb_s2_cyc   = s_cyc_s[2];

  assign busy_o    = busy_r;
  assign timeout_o = timeout_r;
  assign decerr_o  = decerr_r;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// tb_wb_slave_decoder: random and directed Wishbone accesses checked cycle by
// cycle against a transaction-level model of the decoder's windows and timing.
module tb_wb_slave_decoder;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m_adr, m_dat_o, m_dat_i;
  logic        m_we, m_stb, m_cyc, m_ack, m_err, m_rty;
  logic [3:0]  m_sel;
  logic [31:0] so_adr [3];
  logic [31:0] so_dat [3];
  logic        so_we  [3];
  logic [3:0]  so_sel [3];
  logic        so_stb [3];
  logic        so_cyc [3];
  logic [31:0] si_dat [3];
  logic        si_ack [3];
  logic        si_err [3];
  logic        si_rty [3];
  logic        busy_o, timeout_o, decerr_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wb_slave_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_m_adr(m_adr), .wb_m_dat_o(m_dat_o), .wb_m_we(m_we), .wb_m_sel(m_sel),
    .wb_m_stb(m_stb), .wb_m_cyc(m_cyc), .wb_m_dat_i(m_dat_i),
    .wb_m_ack(m_ack), .wb_m_err(m_err), .wb_m_rty(m_rty),
    .wb_s0_adr(so_adr[0]), .wb_s0_dat_o(so_dat[0]), .wb_s0_we(so_we[0]), .wb_s0_sel(so_sel[0]),
    .wb_s0_stb(so_stb[0]), .wb_s0_cyc(so_cyc[0]), .wb_s0_dat_i(si_dat[0]),
    .wb_s0_ack(si_ack[0]), .wb_s0_err(si_err[0]), .wb_s0_rty(si_rty[0]),
    .wb_s1_adr(so_adr[1]), .wb_s1_dat_o(so_dat[1]), .wb_s1_we(so_we[1]), .wb_s1_sel(so_sel[1]),
    .wb_s1_stb(so_stb[1]), .wb_s1_cyc(so_cyc[1]), .wb_s1_dat_i(si_dat[1]),
    .wb_s1_ack(si_ack[1]), .wb_s1_err(si_err[1]), .wb_s1_rty(si_rty[1]),
    .wb_s2_adr(so_adr[2]), .wb_s2_dat_o(so_dat[2]), .wb_s2_we(so_we[2]), .wb_s2_sel(so_sel[2]),
    .wb_s2_stb(so_stb[2]), .wb_s2_cyc(so_cyc[2]), .wb_s2_dat_i(si_dat[2]),
    .wb_s2_ack(si_ack[2]), .wb_s2_err(si_err[2]), .wb_s2_rty(si_rty[2]),
    .busy_o(busy_o), .timeout_o(timeout_o), .decerr_o(decerr_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode: plain address-range membership, S0 first, -1 for no window
  function automatic int ref_target(input logic [31:0] adr);
    if (adr >= 32'h8000_0000 && adr < 32'h8040_0000) return 0;
    if (adr >= 32'h8040_0000 && adr < 32'h8080_0000) return 1;
    if (adr >= 32'h1000_0000 && adr < 32'h1001_0000) return 2;
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Random read data on every slave and random stray responses, except a quiet one
  task automatic rand_slaves(input int quiet);
    for (int k = 0; k < 3; k++) begin
      int r;
      r = int'($urandom % 4);
      si_dat[k] = $urandom;
      si_ack[k] = (r == 1) && (k != quiet);
      si_err[k] = (r == 2) && (k != quiet);
      si_rty[k] = (r == 3) && (k != quiet);
    end
  endtask

  // Compare every DUT output against the expectation for this cycle
  task automatic check_cycle(input string tag, input int route, input logic e_ack,
                             input logic e_err, input logic e_rty, input logic e_busy,
                             input logic e_to, input logic e_de);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_s%0d_cyc", tag, k), so_cyc[k], (k == route) ? m_cyc : 1'b0);
      chk($sformatf("%s_s%0d_stb", tag, k), so_stb[k], (k == route) ? m_stb : 1'b0);
      chk($sformatf("%s_s%0d_adr", tag, k), so_adr[k], (k == route) ? m_adr : 32'h0);
      chk($sformatf("%s_s%0d_dat", tag, k), so_dat[k], (k == route) ? m_dat_o : 32'h0);
      chk($sformatf("%s_s%0d_we", tag, k), so_we[k], (k == route) ? m_we : 1'b0);
      chk($sformatf("%s_s%0d_sel", tag, k), so_sel[k], (k == route) ? m_sel : 4'h0);
    end
    chk({tag, "_ack"}, m_ack, e_ack);
    chk({tag, "_err"}, m_err, e_err);
    chk({tag, "_rty"}, m_rty, e_rty);
    chk({tag, "_dat_i"}, m_dat_i, (route >= 0) ? si_dat[route] : 32'h0);
    chk({tag, "_busy"}, busy_o, e_busy);
    chk({tag, "_timeout"}, timeout_o, e_to);
    chk({tag, "_decerr"}, decerr_o, e_de);
  endtask

  // One master access. delay = active cycle index on which the target responds
  // (beyond TO means never), rtype 0/1/2 = ack/err/rty, abort_at = active cycle
  // on which the master drops cyc (-1 = none), hold = keep cyc/stb for the next access.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int delay, input int rtype,
                         input int abort_at, input bit hold);
    int  tgt;
    int  a;
    bit  done;
    tgt = ref_target(adr);
    next_cycle();
    m_adr = adr; m_we = we; m_dat_o = wdat; m_sel = sel; m_cyc = 1'b1; m_stb = 1'b1;
    rand_slaves(-1);
    settle();
    check_cycle("req", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (tgt < 0) begin
      next_cycle();
      rand_slaves(-1);
      settle();
      check_cycle("decerr", -1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end else begin
      done = 1'b0;
      a = 0;
      while (!done) begin
        next_cycle();
        if (a > TO) begin
          rand_slaves(-1);
          settle();
          check_cycle("timeout", -1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
          done = 1'b1;
        end else if (a == abort_at) begin
          rand_slaves(tgt);
          m_cyc = 1'b0; m_stb = 1'b0;
          settle();
          check_cycle("abort", tgt, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
          done = 1'b1;
        end else if (a == delay) begin
          rand_slaves(tgt);
          si_ack[tgt] = (rtype == 0);
          si_err[tgt] = (rtype == 1);
          si_rty[tgt] = (rtype == 2);
          settle();
          check_cycle("resp", tgt, rtype == 0, rtype == 1, rtype == 2, 1'b1, 1'b0, 1'b0);
          done = 1'b1;
        end else begin
          rand_slaves(tgt);
          settle();
          check_cycle("wait", tgt, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        a++;
      end
    end
    if (!hold || abort_at >= 0) begin
      next_cycle();
      m_cyc = 1'b0; m_stb = 1'b0;
      rand_slaves(-1);
      if (tgt >= 0) begin
        si_ack[tgt] = 1'b1; si_err[tgt] = 1'b0; si_rty[tgt] = 1'b0;
      end
      settle();
      check_cycle("idle", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  logic [31:0] edge_tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    edge_tbl[0] = 32'h7FFF_FFFC; edge_tbl[1] = 32'h803F_FFFC; edge_tbl[2] = 32'h8080_0000;
    edge_tbl[3] = 32'h0FFF_FFFC; edge_tbl[4] = 32'h1001_0000; edge_tbl[5] = 32'h1000_FFFC;
    rst_i = 1'b1;
    m_adr = 32'h0; m_dat_o = 32'h0; m_we = 1'b0; m_sel = 4'h0; m_cyc = 1'b0; m_stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      si_dat[k] = 32'h0; si_ack[k] = 1'b0; si_err[k] = 1'b0; si_rty[k] = 1'b0;
    end
    next_cycle();
    next_cycle();
    settle();
    check_cycle("reset", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;

    // directed scenarios
    run_txn(32'h8000_0010, 1'b0, 32'h0, 4'hF, 2, 0, -1, 1'b0);    // S0 read, ack after 2
    run_txn(32'h1000_0004, 1'b1, 32'h55, 4'b0001, 0, 0, -1, 1'b0); // S2 write
    run_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 0, 0, -1, 1'b0);    // decode error
    run_txn(32'h8040_0100, 1'b0, 32'h0, 4'hF, 99, 0, -1, 1'b0);   // S1 timeout
    run_txn(32'h8000_0020, 1'b0, 32'h0, 4'hF, 99, 0, 1, 1'b0);    // master abort
    run_txn(32'h8000_0030, 1'b0, 32'h0, 4'hF, 1, 0, -1, 1'b1);    // back-to-back S0 ...
    run_txn(32'h1000_0008, 1'b0, 32'h0, 4'hF, 1, 0, -1, 1'b0);    // ... then S2
    run_txn(32'h8040_0000, 1'b0, 32'h0, 4'hF, TO, 0, -1, 1'b0);   // ack on the limit cycle

    // randomized accesses
    for (int n = 0; n < 300; n++) begin
      logic [31:0] adr;
      int          pick;
      int          delay;
      int          abort_at;
      bit          hold;
      pick = int'($urandom % 5);
      case (pick)
        0:       adr = 32'h8000_0000 + ($urandom % 32'h0040_0000);
        1:       adr = 32'h8040_0000 + ($urandom % 32'h0040_0000);
        2:       adr = 32'h1000_0000 + ($urandom % 32'h0001_0000);
        3:       adr = $urandom;
        default: adr = edge_tbl[$urandom % 6];
      endcase
      delay    = int'($urandom % 7);
      abort_at = (($urandom % 8) == 0) ? int'($urandom % 3) : -1;
      if (abort_at >= delay) abort_at = -1;
      hold     = (($urandom % 2) == 1) && (abort_at < 0);
      run_txn(adr, 1'($urandom % 2), $urandom, 4'($urandom % 16), delay,
              int'($urandom % 3), abort_at, hold);
    end

    // reset in the middle of an S0 access, then a late S0 ack
    next_cycle();
    m_adr = 32'h8000_0040; m_we = 1'b0; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    rand_slaves(-1);
    settle();
    check_cycle("rst_req", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rand_slaves(0);
    rst_i = 1'b1;
    settle();
    check_cycle("rst_act", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    rst_i = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0;
    rand_slaves(-1);
    si_ack[0] = 1'b1; si_err[0] = 1'b0; si_rty[0] = 1'b0;
    settle();
    check_cycle("rst_abort", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_slave_decoder.md
WB_SLAVE_DECODER -- requirements
Module: wb_slave_decoder

Interface
REQ-001 SHALL take parameters: ADDR_WIDTH, default 32, address width.
REQ-002 SHALL take parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL take parameter TIMEOUT_CYCLES, default 255, maximum cycles a slave may stall before the decoder aborts the access (range 1..65535).
REQ-004 SHALL take parameters S0_BASE/S0_MASK, defaults 32'h8000_0000/32'hFFC0_0000, BaseRAM window.
REQ-005 SHALL take parameters S1_BASE/S1_MASK, defaults 32'h8040_0000/32'hFFC0_0000, ExtRAM window.
REQ-006 SHALL take parameters S2_BASE/S2_MASK, defaults 32'h1000_0000/32'hFFFF_0000, UART window.
REQ-007 SHALL have ports, clock and reset first, as listed below.
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- wb_m  wishbone_if.slave  -  upstream port (adr, dat_o, we, sel, stb, cyc in; dat_i, ack, err, rty out).
- wb_s0, wb_s1, wb_s2  wishbone_if.master  -  downstream slave ports (adr, dat_o, we, sel, stb, cyc out; dat_i, ack, err, rty in).
- busy_o  out  1  high while state != IDLE.
- timeout_o  out  1  one-cycle pulse when an access is aborted by timeout.
- decerr_o  out  1  one-cycle pulse when an access hits no window.

Function
REQ-008 SHALL define hit_k = ((wb_m.adr & Sk_MASK) == Sk_BASE); on overlap, priority is S0 > S1 > S2.
REQ-009 SHALL implement states IDLE, ACTIVE, DECERR, TIMEOUT.
REQ-010 IDLE: all slave cyc/stb = 0, all wb_m returns = 0; on wb_m.cyc & wb_m.stb, the decoder SHALL register the selected index sel_q (2 bits) and go to ACTIVE if any hit_k, else to DECERR. This is a fixed one-cycle decode latency.
REQ-011 ACTIVE: adr, dat_o, we, sel, stb and cyc of wb_m SHALL be routed combinationally to slave sel_q only, and that slave's dat_i, ack, err and rty routed to wb_m. Non-selected slaves SHALL see cyc = stb = 0 and adr/dat_o/we/sel = 0.
REQ-012 ACTIVE SHALL exit to IDLE on the cycle in which the selected slave asserts ack, err or rty, or in which wb_m.cyc = 0 (master abort). The slave's cyc then falls combinationally in that same cycle.
REQ-013 A 16-bit wait counter SHALL clear on entry to ACTIVE and increment each ACTIVE cycle without ack/err/rty. When it equals TIMEOUT_CYCLES, the next state SHALL be TIMEOUT.
REQ-014 TIMEOUT, exactly one cycle: all slave cyc/stb = 0; wb_m.err = 1, wb_m.ack = 0, timeout_o = 1; then go to IDLE.
REQ-015 DECERR, exactly one cycle: wb_m.err = 1, decerr_o = 1, no slave cyc; then go to IDLE.
REQ-016 wb_m.ack and wb_m.err SHALL never be asserted together.
REQ-017 wb_m.dat_i SHALL be 0 outside ACTIVE.
REQ-018 After any completion, the decoder SHALL pass through IDLE for at least one cycle. Back-to-back accesses therefore have one dead cycle, and a master holding cyc&stb is re-decoded using the current adr.
REQ-019 A slave ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take precedence: normal completion, no timeout.
REQ-020 The decoder SHALL ignore ack/err/rty from non-selected slaves at all times.

Reset
REQ-021 On rst_i high at a clock edge: state = IDLE, sel_q = 0, wait counter = 0, timeout_o = decerr_o = busy_o = 0.
REQ-022 Asserting rst_i mid-access SHALL abort the access: all slave cyc/stb and all wb_m returns are 0 from the next cycle. A late slave ack after reset SHALL be ignored.

Verification
REQ-023 Read 0x8000_0010, S0 acks 2 cycles after cyc -> only wb_s0.cyc high; wb_m.ack and dat_i = S0 data in the same cycle; busy_o falls next cycle.
REQ-024 Write 0x1000_0004, dat 0x55, sel 4'b0001 -> only wb_s2 sees we = 1, dat_o = 0x55; S2 ack passed to wb_m.
REQ-025 Access 0x0000_0000 -> no slave cyc; wb_m.err and decerr_o high for exactly one cycle, 1 cycle after stb.
REQ-026 TIMEOUT_CYCLES = 4, S1 never acks -> wb_s1.cyc high 5 cycles, then wb_m.err + timeout_o for 1 cycle; stray S1 ack in IDLE ignored.
REQ-027 Master drops cyc in ACTIVE, then S0 acks next cycle -> state IDLE, wb_m.ack stays 0.
REQ-028 Two back-to-back reads to S0 then S2 -> one IDLE cycle between them; each is routed to the correct slave.
